multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have ports: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: instruction  input  32  instruction register contents; opcode [6:0], func3 [14:12].
REQ-005 SHALL have ports: zero  input  1  ALU zero flag; mem_ready  input  1  memory completes the current request.
REQ-006 SHALL have ports: mem_req, mem_we, i_or_d (0 PC, 1 ALU result)  output  1 each  memory request, write enable, address select.
REQ-007 SHALL have ports: pc_write, ir_write, reg_write, mem_to_reg, pc_src (0 ALU, 1 ALUOut)  output  1 each  datapath strobes and selects.
REQ-008 SHALL have ports: alu_src_a  output  2  (00 PC, 01 oldPC, 10 rs1); alu_src_b  output  2  (00 rs2, 01 const 4, 10 imm); alu_oper  output  2  (00 add, 01 compare, 10 funct-decoded).
REQ-009 SHALL have ports: state  output  4  current state; retired  output  CNT_W  retired count; illegal  output  1  trap flag.

Function
REQ-010 SHALL implement states FETCH, DECODE, ADDR, MEM_RD, LOAD_WB, MEM_WR, EXEC, ALU_WB, BRANCH, TRAP; outputs decoded from state (Moore), except pc_write in BRANCH.
REQ-011 FETCH: mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_oper=00; on mem_ready=1: ir_write=1, pc_write=1, pc_src=0, -> DECODE; else hold.
REQ-012 DECODE: alu_src_a=01, alu_src_b=10, add (branch target to ALUOut); opcode 1100011 -> BRANCH, 0000011/0100011 -> ADDR, 0010011/0110011 -> EXEC, other -> illegal handling (REQ-022).
REQ-013 ADDR: alu_src_a=10, alu_src_b=10, add; -> MEM_RD for load, MEM_WR for store.
REQ-014 MEM_RD: mem_req=1, i_or_d=1; on mem_ready -> LOAD_WB. LOAD_WB: reg_write=1, mem_to_reg=1, -> FETCH.
REQ-015 MEM_WR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready -> FETCH.
REQ-016 EXEC: alu_src_a=10, alu_src_b=10 for 0010011 else 00, alu_oper=10, -> ALU_WB. ALU_WB: reg_write=1, mem_to_reg=0, -> FETCH.
REQ-017 BRANCH: alu_src_a=10, alu_src_b=00, alu_oper=01, pc_src=1; pc_write=zero for func3 000, ~zero for 001, 0 otherwise; -> FETCH.
REQ-018 Handshake: mem_req, mem_we, i_or_d SHALL stay stable while waiting; completion in the cycle mem_ready=1 is sampled with mem_req=1; mem_ready ignored otherwise; zero wait states give minimum latency (ALU 4, branch 3, store 4, load 5 cycles).
REQ-019 retired SHALL increment by 1 on leaving LOAD_WB, ALU_WB, BRANCH, or MEM_WR with mem_ready; wraps from all-ones to 0.
REQ-020 All strobes not listed for a state SHALL be 0; selects default 0.

Reset
REQ-021 reset_n=0 SHALL immediately force state=FETCH, retired=0, illegal=0, and gate every strobe (mem_req, mem_we, pc_write, ir_write, reg_write) to 0, including mid-wait; first fetch request appears the cycle reset_n rises.

Configuration
REQ-022 Macro ILLEGAL_TRAP_EN: defined -> unknown opcode, or branch func3 not 000/001, enters TRAP (all strobes 0, illegal=1, held until reset, not counted); undefined -> illegal tied 0, unknown opcode returns DECODE -> FETCH as NOP, not counted, TRAP unreachable.

Structure
REQ-023 Shared package SHALL hold state encoding, opcode constants, alu_oper/alu_src_a/alu_src_b encodings.
REQ-024 Single module; no sub-module required (next-state and output decode in one file).

Verification
REQ-025 Reset low during FETCH -> mem_req=0, state=FETCH; release, mem_ready=1 constantly, instruction 0x002081B3 -> FETCH,DECODE,EXEC,ALU_WB, reg_write=1 in cycle 4, retired=1.
REQ-026 lw 0x0000A103, mem_ready low 3 cycles in MEM_RD -> mem_req,i_or_d=1 held 4 cycles, then LOAD_WB with reg_write=mem_to_reg=1.
REQ-027 beq 0x00208463 with zero=1 -> pc_write=1,pc_src=1 in BRANCH; zero=0 -> pc_write=0; bne 0x00209463 inverse.
REQ-028 sw 0x0020A023 -> mem_req=mem_we=1 in MEM_WR, reg_write never 1, retired+1 on mem_ready.
REQ-029 0xFFFFFFFF: macro defined -> TRAP, illegal=1 stable 10 cycles; undefined -> FETCH after DECODE, retired unchanged.
REQ-030 reset_n low while waiting in MEM_WR -> mem_req, mem_we drop same cycle; retired=0 at 0xFFFF+1 wrap check (CNT_W=16) -> 0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
//   - state_e    : FSM state encoding. It is also driven on the 4-bit `state` debug port.
//   - OP_*       : RV32I opcodes the controller decodes.
//   - F3_*       : branch func3 values.
//   - alu_src_a_e, alu_src_b_e, alu_oper_e : datapath select encodings.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_ADDR    = 4'd2,
    S_MEM_RD  = 4'd3,
    S_LOAD_WB = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC    = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_TRAP    = 4'd9
  } state_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_FOUR = 2'b01,
    SRC_B_IMM  = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_CMP   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_oper_e;

  // Branch func3 values that have a defined pc_write rule.
  function automatic logic is_known_branch(input logic [2:0] func3);
    return (func3 == F3_BEQ) || (func3 == F3_BNE);
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM.
//
// Supported instruction classes: load, store, OP-IMM, OP and BEQ/BNE.
//
// The outputs are decoded from the state (Moore) with two exceptions:
//   - The FETCH completion strobes depend on mem_ready.
//   - The BRANCH pc_write depends on zero.
//
// Ports:
//   clk, reset_n         single clock; asynchronous active-low reset
//   instruction[31:0]    IR contents (opcode [6:0], func3 [14:12])
//   zero, mem_ready      ALU zero flag, memory request completion
//   mem_req/mem_we/i_or_d            memory request, write enable, address select
//   pc_write/ir_write/reg_write      datapath strobes
//   mem_to_reg/pc_src                datapath selects
//   alu_src_a/alu_src_b/alu_oper     ALU selects
//   state[3:0]           current FSM state
//   retired[CNT_W-1:0]   retired-instruction count
//   illegal              trap flag
//
// Memory handshake: mem_req, mem_we and i_or_d are decoded only from the
// state, so they hold steady while a request waits. A request completes on
// the rising edge where mem_ready=1 is sampled with mem_req=1. mem_ready is
// ignored in every state that does not issue a request.
//
// Optional feature, macro ILLEGAL_TRAP_EN:
//   - Defined: an unknown opcode, or a branch whose func3 is neither BEQ nor
//     BNE, parks the FSM in TRAP with illegal=1 until reset.
//   - Undefined: an unknown opcode is treated as a NOP. illegal is tied to 0.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_oper,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] func3;
  assign opcode = instruction[6:0];
  assign func3  = instruction[14:12];

  // The remaining instruction fields belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  logic       retire;
  logic       mem_req_c, mem_we_c, pc_write_c, ir_write_c, reg_write_c;
  alu_src_a_e src_a;
  alu_src_b_e src_b;
  alu_oper_e  oper;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    i_or_d      = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_to_reg  = 1'b0;
    pc_src      = 1'b0;
    src_a       = SRC_A_PC;
    src_b       = SRC_B_RS2;
    oper        = ALU_ADD;

    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        src_b     = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target (oldPC + imm) into ALUOut.
        src_a = SRC_A_OLDPC;
        src_b = SRC_B_IMM;
        case (opcode)
`ifdef ILLEGAL_TRAP_EN
          OP_BRANCH:        state_d = is_known_branch(func3) ? S_BRANCH : S_TRAP;
`else
          OP_BRANCH:        state_d = S_BRANCH;
`endif
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_IMM, OP_REG:    state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_ADDR: begin
        src_a   = SRC_A_RS1;
        src_b   = SRC_B_IMM;
        state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        src_a   = SRC_A_RS1;
        src_b   = (opcode == OP_IMM) ? SRC_B_IMM : SRC_B_RS2;
        oper    = ALU_FUNCT;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a  = SRC_A_RS1;
        src_b  = SRC_B_RS2;
        oper   = ALU_CMP;
        pc_src = 1'b1;
        if (func3 == F3_BEQ)      pc_write_c = zero;
        else if (func3 == F3_BNE) pc_write_c = ~zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  state_d = S_TRAP;
`else
      S_TRAP:  state_d = S_FETCH;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  // Reset is applied asynchronously to the state register. The strobes are
  // also gated combinationally, so they drop in the same cycle that reset_n
  // falls, including while a memory request is waiting.
  assign mem_req   = mem_req_c   & reset_n;
  assign mem_we    = mem_we_c    & reset_n;
  assign pc_write  = pc_write_c  & reset_n;
  assign ir_write  = ir_write_c  & reset_n;
  assign reg_write = reg_write_c & reset_n;

  assign alu_src_a = src_a;
  assign alu_src_b = src_b;
  assign alu_oper  = oper;
  assign state     = state_q;
  assign retired   = retired_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller.
//
// The driver applies one set of inputs per cycle, #1 after the rising edge.
// For that cycle it pushes the expected outputs, tagged with the cycle number.
// A monitor on the falling edge pops the entries due in that cycle and compares:
//   - the main instance (CNT_W=16) against the full expected vector;
//   - a narrow instance (CNT_W=3) that sees the same inputs, against the same
//     vector with its retired count taken modulo 8. This exercises counter wrap.
// The expected vectors are built from hand-written constants.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_ADDR = 4'd2,
                         S_MEM_RD = 4'd3, S_LOAD_WB = 4'd4, S_MEM_WR = 4'd5,
                         S_EXEC = 4'd6, S_ALU_WB = 4'd7, S_BRANCH = 4'd8,
                         S_TRAP = 4'd9;

  // Strobe order: mem_req mem_we i_or_d pc_write ir_write reg_write mem_to_reg pc_src.
  localparam logic [7:0] STB_NONE  = 8'b0000_0000;
  localparam logic [7:0] STB_FWAIT = 8'b1000_0000;
  localparam logic [7:0] STB_FGO   = 8'b1001_1000;
  localparam logic [7:0] STB_MRD   = 8'b1010_0000;
  localparam logic [7:0] STB_MWR   = 8'b1110_0000;
  localparam logic [7:0] STB_LWB   = 8'b0000_0110;
  localparam logic [7:0] STB_AWB   = 8'b0000_0100;
  localparam logic [7:0] STB_BR_T  = 8'b0001_0001;
  localparam logic [7:0] STB_BR_N  = 8'b0000_0001;

  // Select order: alu_src_a alu_src_b alu_oper.
  localparam logic [5:0] SEL_0     = 6'b00_00_00;
  localparam logic [5:0] SEL_FETCH = 6'b00_01_00;
  localparam logic [5:0] SEL_DEC   = 6'b01_10_00;
  localparam logic [5:0] SEL_ADDR  = 6'b10_10_00;
  localparam logic [5:0] SEL_EXR   = 6'b10_00_10;
  localparam logic [5:0] SEL_EXI   = 6'b10_10_10;
  localparam logic [5:0] SEL_BR    = 6'b10_00_01;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instruction;
  logic        zero, mem_ready;

  logic        mem_req, mem_we, i_or_d, pc_write, ir_write, reg_write, mem_to_reg, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, alu_oper;
  logic [3:0]  state;
  logic [15:0] retired;
  logic        illegal;

  logic        s_mem_req, s_mem_we, s_i_or_d, s_pc_write, s_ir_write, s_reg_write;
  logic        s_mem_to_reg, s_pc_src;
  logic [1:0]  s_alu_src_a, s_alu_src_b, s_alu_oper;
  logic [3:0]  s_state;
  logic [2:0]  s_retired;
  logic        s_illegal;

  multicycle_controller #(.CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_oper(alu_oper), .state(state),
    .retired(retired), .illegal(illegal)
  );

  multicycle_controller #(.CNT_W(3)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .mem_req(s_mem_req), .mem_we(s_mem_we), .i_or_d(s_i_or_d),
    .pc_write(s_pc_write), .ir_write(s_ir_write), .reg_write(s_reg_write),
    .mem_to_reg(s_mem_to_reg), .pc_src(s_pc_src), .alu_src_a(s_alu_src_a),
    .alu_src_b(s_alu_src_b), .alu_oper(s_alu_oper), .state(s_state),
    .retired(s_retired), .illegal(s_illegal)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // Expected layout: {state[3:0], strobes[7:0], selects[5:0], illegal, retired[15:0], retired mod 8}.
  logic [37:0] exp_q[$];
  int          cyc_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] r = 16'd0;

  function automatic logic [37:0] ex(input logic [3:0] st, input logic [7:0] stb,
                                     input logic [5:0] sel, input logic ill,
                                     input logic [15:0] ret);
    return {st, stb, sel, ill, ret, ret[2:0]};
  endfunction

  logic [37:0] m_exp;
  logic [34:0] m_act, m_want;
  logic [21:0] m_sact, m_swant;
  int          m_cyc;
  string       m_name;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
      m_exp  = exp_q.pop_front();
      m_cyc  = cyc_q.pop_front();
      m_name = name_q.pop_front();
      if (m_cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d still pending at cycle %0d", m_name, m_cyc, cyc);
      end else begin
        m_act  = {state, mem_req, mem_we, i_or_d, pc_write, ir_write, reg_write,
                  mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_oper, illegal, retired};
        m_want = m_exp[37:3];
        checks++;
        if (m_act !== m_want) begin
          errors++;
          $display("FAIL %s (cycle %0d): got %h want %h", m_name, cyc, m_act, m_want);
        end
        m_sact  = {s_state, s_mem_req, s_mem_we, s_i_or_d, s_pc_write, s_ir_write,
                   s_reg_write, s_mem_to_reg, s_pc_src, s_alu_src_a, s_alu_src_b,
                   s_alu_oper, s_illegal, s_retired};
        m_swant = {m_exp[37:19], m_exp[2:0]};
        checks++;
        if (m_sact !== m_swant) begin
          errors++;
          $display("FAIL %s_narrow (cycle %0d): got %h want %h", m_name, cyc, m_sact, m_swant);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [31:0] ins, input logic z, input logic rdy,
                      input logic rst, input logic [37:0] e, input string nm);
    @(posedge clk);
    #1;
    instruction = ins;
    zero        = z;
    mem_ready   = rdy;
    reset_n     = rst;
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    name_q.push_back(nm);
  endtask

  task automatic fetch(input logic [31:0] ins, input int waits);
    for (int i = 0; i < waits; i++)
      step(ins, 1'b0, 1'b0, 1'b1, ex(S_FETCH, STB_FWAIT, SEL_FETCH, 1'b0, r), "fetch_wait");
    step(ins, 1'b0, 1'b1, 1'b1, ex(S_FETCH, STB_FGO, SEL_FETCH, 1'b0, r), "fetch_go");
    // mem_ready stays high in DECODE and must be ignored there.
    step(ins, 1'b0, 1'b1, 1'b1, ex(S_DECODE, STB_NONE, SEL_DEC, 1'b0, r), "decode");
  endtask

  task automatic do_alu(input logic [31:0] ins, input logic itype);
    fetch(ins, 0);
    step(ins, 1'b0, 1'b1, 1'b1, ex(S_EXEC, STB_NONE, itype ? SEL_EXI : SEL_EXR, 1'b0, r), "exec");
    step(ins, 1'b0, 1'b1, 1'b1, ex(S_ALU_WB, STB_AWB, SEL_0, 1'b0, r), "alu_wb");
    r = r + 16'd1;
  endtask

  task automatic do_load(input logic [31:0] ins, input int waits);
    fetch(ins, 1);
    step(ins, 1'b0, 1'b0, 1'b1, ex(S_ADDR, STB_NONE, SEL_ADDR, 1'b0, r), "addr_ld");
    for (int i = 0; i < waits; i++)
      step(ins, 1'b0, 1'b0, 1'b1, ex(S_MEM_RD, STB_MRD, SEL_0, 1'b0, r), "mem_rd_wait");
    step(ins, 1'b0, 1'b1, 1'b1, ex(S_MEM_RD, STB_MRD, SEL_0, 1'b0, r), "mem_rd_go");
    step(ins, 1'b0, 1'b1, 1'b1, ex(S_LOAD_WB, STB_LWB, SEL_0, 1'b0, r), "load_wb");
    r = r + 16'd1;
  endtask

  task automatic do_store(input logic [31:0] ins, input int waits);
    fetch(ins, 0);
    step(ins, 1'b0, 1'b0, 1'b1, ex(S_ADDR, STB_NONE, SEL_ADDR, 1'b0, r), "addr_st");
    for (int i = 0; i < waits; i++)
      step(ins, 1'b0, 1'b0, 1'b1, ex(S_MEM_WR, STB_MWR, SEL_0, 1'b0, r), "mem_wr_wait");
    step(ins, 1'b0, 1'b1, 1'b1, ex(S_MEM_WR, STB_MWR, SEL_0, 1'b0, r), "mem_wr_go");
    r = r + 16'd1;
  endtask

  task automatic do_branch(input logic [31:0] ins, input logic z, input logic taken);
    fetch(ins, 0);
    step(ins, z, 1'b1, 1'b1, ex(S_BRANCH, taken ? STB_BR_T : STB_BR_N, SEL_BR, 1'b0, r), "branch");
    r = r + 16'd1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n     = 1'b0;
    instruction = I_ADD;
    zero        = 1'b0;
    mem_ready   = 1'b1;

    // Reset held during FETCH with mem_ready high: every strobe stays gated.
    step(I_ADD, 1'b0, 1'b1, 1'b0, ex(S_FETCH, STB_NONE, SEL_FETCH, 1'b0, 16'd0), "reset_fetch");
    step(I_ADD, 1'b0, 1'b1, 1'b0, ex(S_FETCH, STB_NONE, SEL_FETCH, 1'b0, 16'd0), "reset_fetch");

    // Release into add: FETCH, DECODE, EXEC, ALU_WB, then retired=1.
    do_alu(I_ADD, 1'b0);
    do_load(I_LW, 3);
    do_store(I_SW, 1);
    do_branch(I_BEQ, 1'b1, 1'b1);
    do_branch(I_BEQ, 1'b0, 1'b0);
    do_branch(I_BNE, 1'b1, 1'b0);
    do_branch(I_BNE, 1'b0, 1'b1);
    // Eighth retirement: the narrow counter wraps 7 -> 0.
    do_alu(I_ADDI, 1'b1);

    // Unknown opcode.
    fetch(I_BAD, 0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      step(I_BAD, 1'b1, 1'b1, 1'b1, ex(S_TRAP, STB_NONE, SEL_0, 1'b1, r), "trap_hold");
`else
    step(I_BAD, 1'b0, 1'b0, 1'b1, ex(S_FETCH, STB_FWAIT, SEL_FETCH, 1'b0, r), "nop_refetch");
`endif

    // Reset pulse clears the counter and any trap.
    r = 16'd0;
    step(I_SW, 1'b0, 1'b1, 1'b0, ex(S_FETCH, STB_NONE, SEL_FETCH, 1'b0, r), "reset_pulse");

    // Reset while a store waits: mem_req and mem_we drop in the same cycle.
    fetch(I_SW, 0);
    step(I_SW, 1'b0, 1'b0, 1'b1, ex(S_ADDR, STB_NONE, SEL_ADDR, 1'b0, r), "addr_st");
    step(I_SW, 1'b0, 1'b0, 1'b1, ex(S_MEM_WR, STB_MWR, SEL_0, 1'b0, r), "mem_wr_wait");
    step(I_SW, 1'b0, 1'b0, 1'b0, ex(S_FETCH, STB_NONE, SEL_FETCH, 1'b0, r), "reset_mid_wr");
    step(I_SW, 1'b0, 1'b0, 1'b1, ex(S_FETCH, STB_FWAIT, SEL_FETCH, 1'b0, r), "fetch_after_rst");
    do_alu(I_ADD, 1'b0);
    step(I_ADD, 1'b0, 1'b0, 1'b1, ex(S_FETCH, STB_FWAIT, SEL_FETCH, 1'b0, r), "final_fetch");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
